// File: rtl/apb_pkg.sv
// Shared APB bridge types: FSM state encoding and default bus widths.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response port plus APB initiator signals for apb_master_bridge.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    // Bridge side
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    // Requester plus APB responder side
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB initiator with registered one-cycle response.
// Define APB_MASTER_TIMEOUT_EN to abort stalled ACCESS phases with rsp_err.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                 clk,
    input logic                 resetn,
    apb_master_bridge_if.master bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gen_timeout_range
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    apb_state_e        state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       rsp_err_q, rsp_err_d;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d  = SETUP;
                    pwrite_d = bus.req_write;
                    paddr_d  = bus.req_addr;
                    pwdata_d = bus.req_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: begin
                // pready wins over a timeout landing on the same edge
                if (bus.pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // psel/penable decode straight from state so reset drops them immediately
    assign bus.req_ready = (state_q == IDLE);
    assign bus.psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable   = (state_q == ACCESS);
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed table-driven bench for apb_master_bridge plus multi-cycle corner sequences.
module tb_apb_master_bridge;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    apb_master_bridge_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    apb_master_bridge #(
        .ADDR_W         (8),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int unsigned waits;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("idle_psel", {31'd0, bus.psel}, 32'd0);
        bus.req_valid = 1'b1;
        bus.req_write = v.wr;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.pready    = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("setup_psel", {31'd0, bus.psel}, 32'd1);
        chk("setup_penable", {31'd0, bus.penable}, 32'd0);
        chk("setup_paddr", {24'd0, bus.paddr}, {24'd0, v.addr});
        chk("setup_pwdata", bus.pwdata, v.wdata);
        chk("setup_pwrite", {31'd0, bus.pwrite}, {31'd0, v.wr});
        chk("setup_ready", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("access_psel", {31'd0, bus.psel}, 32'd1);
        chk("access_penable", {31'd0, bus.penable}, 32'd1);
        for (int k = 0; k <= int'(v.waits); k++) begin
            bus.pready = (k == int'(v.waits));
            bus.prdata = bus.pready ? v.prdata : ~v.prdata;
            @(posedge clk); #1;
            if (k < int'(v.waits)) begin
                chk("wait_penable", {31'd0, bus.penable}, 32'd1);
                chk("wait_rsp", {31'd0, bus.rsp_valid}, 32'd0);
                chk("wait_paddr", {24'd0, bus.paddr}, {24'd0, v.addr});
            end
        end
        bus.pready = 1'b0;
        chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
        chk("rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("done_psel", {31'd0, bus.psel}, 32'd0);
        chk("done_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        chk("rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rsp_hold", bus.rsp_rdata, v.exp_rdata);
    endtask

    // Accept one request and leave the bench in the SETUP cycle.
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       b2b_psel [6];
        logic       b2b_pen  [6];
        logic       b2b_rsp  [6];
        logic [7:0] b2b_addr [6];
        int         acc;
        bit         seen;

        checks = 0;
        errors = 0;
        vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0BAD0BAD, 32'h0};
        vecs[1] = '{1'b0, 8'h04, 32'h0, 3, 32'h000000A5, 32'h000000A5};
        vecs[2] = '{1'b1, 8'hFF, 32'h12345678, 1, 32'hFFFFFFFF, 32'h0};
        vecs[3] = '{1'b0, 8'h00, 32'h55555555, 0, 32'hCAFEF00D, 32'hCAFEF00D};
        b2b_psel = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        b2b_pen  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        b2b_rsp  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        b2b_addr = '{8'h20, 8'h20, 8'h20, 8'h24, 8'h24, 8'h24};

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        resetn        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel", {31'd0, bus.psel}, 32'd0);
        chk("rst_penable", {31'd0, bus.penable}, 32'd0);
        chk("rst_pwrite", {31'd0, bus.pwrite}, 32'd0);
        chk("rst_paddr", {24'd0, bus.paddr}, 32'd0);
        chk("rst_pwdata", bus.pwdata, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back: second request held and accepted in the first rsp_valid cycle
        @(negedge clk);
        bus.pready    = 1'b1;
        bus.prdata    = 32'h5A5A0000;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h20;
        bus.req_wdata = 32'h11111111;
        @(posedge clk); #1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h24;
        for (int c = 0; c < 6; c++) begin
            chk("b2b_psel", {31'd0, bus.psel}, {31'd0, b2b_psel[c]});
            chk("b2b_penable", {31'd0, bus.penable}, {31'd0, b2b_pen[c]});
            chk("b2b_rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, b2b_rsp[c]});
            chk("b2b_paddr", {24'd0, bus.paddr}, {24'd0, b2b_addr[c]});
            if (c == 2) chk("b2b_rdata_wr", bus.rsp_rdata, 32'h0);
            if (c == 5) chk("b2b_rdata_rd", bus.rsp_rdata, 32'h5A5A0000);
            if (c == 3) bus.req_valid = 1'b0;
            if (c < 5) begin
                @(posedge clk); #1;
            end
        end
        bus.pready = 1'b0;

        // Requests arriving mid-transfer must not disturb the latched address
        issue(1'b0, 8'h30, 32'hABCD0001);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h44;
        bus.req_wdata = 32'hFFFF0000;
        chk("ign_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("ign_setup_paddr", {24'd0, bus.paddr}, 32'h30);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("ign_acc_paddr", {24'd0, bus.paddr}, 32'h30);
        chk("ign_acc_pwrite", {31'd0, bus.pwrite}, 32'd0);
        chk("ign_acc_pwdata", bus.pwdata, 32'hABCD0001);
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        chk("ign_acc2_paddr", {24'd0, bus.paddr}, 32'h30);
        chk("ign_acc2_penable", {31'd0, bus.penable}, 32'd1);
        bus.req_valid = 1'b0;
        bus.pready    = 1'b1;
        bus.prdata    = 32'h00000077;
        @(posedge clk); #1;
        bus.pready = 1'b0;
        chk("ign_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("ign_rsp_rdata", bus.rsp_rdata, 32'h77);
        @(posedge clk); #1;
        chk("ign_no_stray", {31'd0, bus.psel}, 32'd0);

`ifdef APB_MASTER_TIMEOUT_EN
        // Stalled responder: 16 ACCESS cycles then error response
        issue(1'b0, 8'h08, 32'h0);
        acc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1'b1;
            else if (bus.penable) acc++;
        end
        chk("to_seen", {31'd0, seen}, 32'd1);
        chk("to_access_cycles", acc, 32'd16);
        chk("to_err", {31'd0, bus.rsp_err}, 32'd1);
        chk("to_rdata", bus.rsp_rdata, 32'h0);
        chk("to_psel", {31'd0, bus.psel}, 32'd0);
        // pready on the 16th ACCESS edge completes normally
        issue(1'b0, 8'h0C, 32'h0);
        @(posedge clk); #1;
        bus.prdata = 32'h00000099;
        for (int k = 0; k < 16; k++) begin
            bus.pready = (k == 15);
            @(posedge clk); #1;
        end
        bus.pready = 1'b0;
        chk("to_edge_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("to_edge_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("to_edge_rdata", bus.rsp_rdata, 32'h99);
`else
        // No timeout: ACCESS waits as long as pready stays low
        issue(1'b0, 8'h08, 32'h0);
        @(posedge clk); #1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.penable && !bus.rsp_valid) acc++;
        end
        chk("stall_access_cycles", acc, 32'd20);
        bus.pready = 1'b1;
        bus.prdata = 32'h00000099;
        @(posedge clk); #1;
        bus.pready = 1'b0;
        chk("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("stall_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("stall_rdata", bus.rsp_rdata, 32'h99);
`endif

        // Asynchronous reset in ACCESS abandons the transfer
        issue(1'b1, 8'h50, 32'h13572468);
        @(posedge clk); #1;
        chk("prerst_penable", {31'd0, bus.penable}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_psel", {31'd0, bus.psel}, 32'd0);
        chk("arst_penable", {31'd0, bus.penable}, 32'd0);
        chk("arst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("arst_hold_psel", {31'd0, bus.psel}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid || bus.psel) seen = 1'b1;
        end
        chk("arst_no_stray", {31'd0, seen}, 32'd0);
        chk("arst_ready", {31'd0, bus.req_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
